// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Loads the fetch-stage instruction memory from a byte-wide valid/ready stream.
// A header byte N gives the word count. It is followed by 4*N payload bytes,
// which are assembled MSB-first into 32-bit words. The core is held in reset and
// stall until the load completes.
// Optional build macro: IMEM_BOOT_CHECKSUM_EN. When it is defined, the stream
// ends with an 8-bit XOR checksum of the payload bytes.
//
// state | meaning
// IDLE  | after reset, waiting for start
// HDR   | waiting for the length byte
// RECV  | shifting in payload bytes of the current word
// WRITE | one-cycle memory write strobe for the assembled word
// CHK   | waiting for the checksum byte (checksum build only)
// DONE  | load complete, core released
// ERR   | bad header or checksum, core held in reset
module imem_boot_loader #(
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              load_mem_en,
  output logic [ADDR_W-1:0] load_mem_addr,
  output logic [31:0]       load_mem_data,
  output logic              core_rst_n,
  output logic              core_stall,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int         CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [7:0] MAX_N = 8'(NUM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RECV,
    S_WRITE,
`ifdef IMEM_BOOT_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [CNT_W-1:0]  word_cnt_inc;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       word_q;
  logic [31:0]       word_shift;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_data_q;
  logic              byte_acc;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  // All outputs are decoded from the state register. There is no path from an input to an output.
  assign byte_ready    = (state_q == S_HDR) || (state_q == S_RECV)
`ifdef IMEM_BOOT_CHECKSUM_EN
                         || (state_q == S_CHK)
`endif
                         ;
  assign load_mem_en   = (state_q == S_WRITE);
  assign load_mem_addr = mem_addr_q;
  assign load_mem_data = mem_data_q;
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);
  assign core_rst_n    = (state_q == S_DONE);
  assign core_stall    = (state_q != S_DONE);
  assign busy          = byte_ready || load_mem_en;

  assign byte_acc      = byte_valid && byte_ready;
  assign word_cnt_inc  = word_cnt_q + 1'b1;
  assign word_shift    = {word_q[23:0], byte_data};

  // Load sequencer: header check, word assembly, memory write and (optionally) checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q <= S_HDR;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        S_HDR: begin
          if (byte_acc) begin
            if ((byte_data == 8'd0) || (byte_data > MAX_N)) begin
              state_q <= S_ERR;
            end else begin
              n_q        <= byte_data[CNT_W-1:0];
              word_cnt_q <= '0;
              byte_cnt_q <= '0;
              state_q    <= S_RECV;
            end
          end
        end
        S_RECV: begin
          if (byte_acc) begin
            word_q     <= word_shift;
            byte_cnt_q <= byte_cnt_q + 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q     <= csum_q ^ byte_data;
`endif
            // Latch the write address and data now, so that they hold after the strobe ends.
            if (byte_cnt_q == 2'd3) begin
              mem_addr_q <= ADDR_W'(word_cnt_q);
              mem_data_q <= word_shift;
              state_q    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          word_cnt_q <= word_cnt_inc;
          if (word_cnt_inc == n_q) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            state_q <= S_CHK;
`else
            state_q <= S_DONE;
`endif
          end else begin
            state_q <= S_RECV;
          end
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        S_CHK: begin
          if (byte_acc) begin
            state_q <= (byte_data == csum_q) ? S_DONE : S_ERR;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader. A scoreboard queue of expected memory writes is
// checked by a monitor on every load_mem_en strobe.
module tb_imem_boot_loader;
  localparam int NW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic          load_mem_en;
  logic [AW-1:0] load_mem_addr;
  logic [31:0]   load_mem_data;
  logic          core_rst_n;
  logic          core_stall;
  logic          busy;
  logic          done;
  logic          err;

  imem_boot_loader #(.NUM_WORDS(NW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .load_mem_en(load_mem_en), .load_mem_addr(load_mem_addr), .load_mem_data(load_mem_data),
    .core_rst_n(core_rst_n), .core_stall(core_stall),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  tests = 0;
  int  fails = 0;
  int  wr_cnt = 0;
  int  cyc = 0;
  int  hdr_cyc = 0;
  int  lat = 0;
  logic [31:0] words [NW];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && load_mem_en === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_write: observed addr=0x%0h data=0x%0h, expected no write",
               load_mem_addr, load_mem_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(load_mem_addr), 64'(mon_e.a));
        check("wr_data", 64'(load_mem_data), 64'(mon_e.d));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hdr_cyc = cyc;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit rnd);
    bit acc;
    int guard;
    guard = 0;
    byte_data = b;
    forever begin
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (acc) break;
      guard++;
      if (guard > 200) begin
        tests++;
        fails++;
        $error("FAIL byte_timeout: observed byte 0x%0h not accepted, expected acceptance", b);
        break;
      end
    end
  endtask

  // Send a header and n words. In the checksum build a trailing checksum byte is also sent.
  task automatic send_load(input int n, input bit rnd, input bit pulse_start, input logic [7:0] csum_flip);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    push_byte(8'(n), rnd);
    for (int w = 0; w < n; w++) begin
      exp_q.push_back('{a: AW'(w), d: words[w]});
      for (int k = 3; k >= 0; k--) begin
        b = words[w][8*k +: 8];
        cs = cs ^ b;
        if (pulse_start) start = ($urandom_range(0, 3) == 0);
        push_byte(b, rnd);
      end
    end
    start = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
    push_byte(cs ^ csum_flip, rnd);
`else
    cs = cs ^ csum_flip;
`endif
    byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    int guard;
    guard = 0;
    while (!(done === 1'b1 || err === 1'b1)) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) begin
        tests++;
        fails++;
        $error("FAIL end_timeout: observed no done/err, expected one within 2000 cycles");
        break;
      end
    end
    lat = cyc - hdr_cyc;
  endtask

  initial begin
    // Reset values
    #1;
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_mem_en", 64'(load_mem_en), 64'd0);
    check("rst_addr", 64'(load_mem_addr), 64'd0);
    check("rst_data", 64'(load_mem_data), 64'd0);
    check("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    check("rst_core_stall", 64'(core_stall), 64'd1);
    check("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic two-word load with valid held high; check the latency
    words[0] = 32'h12345678;
    words[1] = 32'hAABBCCDD;
    wr_cnt = 0;
    do_start();
    check("hdr_busy", 64'(busy), 64'd1);
    send_load(2, 1'b0, 1'b0, 8'h00);
    wait_end();
`ifdef IMEM_BOOT_CHECKSUM_EN
    check("basic_latency", 64'(lat), 64'd12);
`else
    check("basic_latency", 64'(lat), 64'd11);
`endif
    check("basic_done", 64'(done), 64'd1);
    check("basic_core_rst_n", 64'(core_rst_n), 64'd1);
    check("basic_core_stall", 64'(core_stall), 64'd0);
    check("basic_busy", 64'(busy), 64'd0);
    check("basic_wr_cnt", 64'(wr_cnt), 64'd2);
    check("basic_addr_hold", 64'(load_mem_addr), 64'd1);
    check("basic_data_hold", 64'(load_mem_data), 64'hAABBCCDD);

    // Header 00 is rejected
    wr_cnt = 0;
    do_start();
    push_byte(8'h00, 1'b0);
    byte_valid = 1'b0;
    wait_end();
    check("hdr0_err", 64'(err), 64'd1);
    check("hdr0_done", 64'(done), 64'd0);
    check("hdr0_core_rst_n", 64'(core_rst_n), 64'd0);
    check("hdr0_no_write", 64'(wr_cnt), 64'd0);
    do_start();
    check("err_restart_err", 64'(err), 64'd0);
    check("err_restart_ready", 64'(byte_ready), 64'd1);

    // Header 0x11 (17) exceeds NUM_WORDS
    push_byte(8'h11, 1'b0);
    byte_valid = 1'b0;
    wait_end();
    check("hdr17_err", 64'(err), 64'd1);
    check("hdr17_core_stall", 64'(core_stall), 64'd1);
    check("hdr17_no_write", 64'(wr_cnt), 64'd0);

    // Header 0x10 (16) is the boundary. Random valid gaps and start pulses during the load.
    for (int i = 0; i < NW; i++) words[i] = $urandom;
    wr_cnt = 0;
    do_start();
    check("full_err_cleared", 64'(err), 64'd0);
    send_load(NW, 1'b1, 1'b1, 8'h00);
    wait_end();
    check("full_done", 64'(done), 64'd1);
    check("full_wr_cnt", 64'(wr_cnt), 64'(NW));
    check("full_q_empty", 64'(exp_q.size()), 64'd0);

    // Restart from DONE: core goes back into reset on the transition edge
    words[0] = 32'hCAFEF00D;
    wr_cnt = 0;
    do_start();
    check("redo_core_rst_n", 64'(core_rst_n), 64'd0);
    check("redo_core_stall", 64'(core_stall), 64'd1);
    check("redo_done", 64'(done), 64'd0);
    check("redo_busy", 64'(busy), 64'd1);
    send_load(1, 1'b0, 1'b0, 8'h00);
    wait_end();
    check("redo_done_end", 64'(done), 64'd1);
    check("redo_wr_cnt", 64'(wr_cnt), 64'd1);

    // Reset asserted after 2 payload bytes
    wr_cnt = 0;
    do_start();
    push_byte(8'h01, 1'b0);
    push_byte(8'hEE, 1'b0);
    push_byte(8'hFF, 1'b0);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_byte_ready", 64'(byte_ready), 64'd0);
    check("midrst_mem_en", 64'(load_mem_en), 64'd0);
    check("midrst_addr_data", 64'({load_mem_addr, load_mem_data}), 64'd0);
    check("midrst_core", 64'({core_rst_n, core_stall}), 64'b01);
    check("midrst_busy_done_err", 64'({busy, done, err}), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle_ready", 64'(byte_ready), 64'd0);
    words[0] = 32'h01020304;
    do_start();
    send_load(1, 1'b0, 1'b0, 8'h00);
    wait_end();
    check("midrst_done", 64'(done), 64'd1);
    check("midrst_wr_cnt", 64'(wr_cnt), 64'd1);

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Checksum match (0x44) and mismatch (0x45)
    words[0] = 32'h11223344;
    wr_cnt = 0;
    do_start();
    send_load(1, 1'b0, 1'b0, 8'h00);
    wait_end();
    check("csum_ok_done", 64'(done), 64'd1);
    check("csum_ok_err", 64'(err), 64'd0);
    do_start();
    send_load(1, 1'b0, 1'b0, 8'h01);
    wait_end();
    check("csum_bad_err", 64'(err), 64'd1);
    check("csum_bad_core_rst_n", 64'(core_rst_n), 64'd0);
    check("csum_wr_cnt", 64'(wr_cnt), 64'd2);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
